// File: rtl/regfile_issue.sv
// -----------------------------------------------------------------------------
// regfile_issue
// Operand-fetch / issue stage that sits in front of the 8-bit ALU.
// It holds the architectural register file, where r0 always reads as zero.
// A one-bit-per-register scoreboard tracks outstanding writes. Read-after-write
// hazards stall the issue_valid/issue_ready handshake.
// Operands are registered, so they reach the ALU one cycle after acceptance.
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   When this macro is defined, a writeback in the same cycle clears the
//   hazard for the ready rule. It also forwards wb_data straight into the
//   operand registers, which saves one stall cycle per back-to-back dependency.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   issue_valid   instruction presented for issue
//   issue_ready   stage can accept this cycle (combinational, 0 during rst)
//   issue_rs      source register for operand d
//   issue_rt      source register for operand c
//   issue_rd      destination register
//   issue_we      instruction will write issue_rd
//   wb_en         writeback strobe
//   wb_addr       writeback register
//   wb_data       writeback value
//   op_d / op_c   registered operands to the ALU
//   op_valid      op_d/op_c hold a newly issued instruction
//   pending       scoreboard vector (debug visibility)
// -----------------------------------------------------------------------------
module regfile_issue #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [ADDR_W-1:0]   issue_rs,
   input  logic [ADDR_W-1:0]   issue_rt,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic                issue_we,
   input  logic                wb_en,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [DATA_W-1:0]   op_d,
   output logic [DATA_W-1:0]   op_c,
   output logic                op_valid,
   output logic [NUM_REGS-1:0] pending
);

   localparam logic [ADDR_W-1:0] R0 = {ADDR_W{1'b0}};

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [NUM_REGS-1:0] pend_eff;
   logic [DATA_W-1:0]   op_d_q;
   logic [DATA_W-1:0]   op_d_d;
   logic [DATA_W-1:0]   op_c_q;
   logic [DATA_W-1:0]   op_c_d;
   logic                op_valid_q;
   logic                op_valid_d;
   logic [DATA_W-1:0]   rs_val;
   logic [DATA_W-1:0]   rt_val;
   logic                accept;

`ifdef REGFILE_WB_BYPASS_EN
   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] v;
      v    = {NUM_REGS{1'b0}};
      v[a] = 1'b1;
      return v;
   endfunction

   // Hazard view and operand read with same-cycle writeback forwarding
   always_comb begin
      if (wb_en) begin
         pend_eff = pending_q & ~onehot(wb_addr);
      end else begin
         pend_eff = pending_q;
      end
      if (issue_rs == R0) begin
         rs_val = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == issue_rs)) begin
         rs_val = wb_data;
      end else begin
         rs_val = regs_q[issue_rs];
      end
      if (issue_rt == R0) begin
         rt_val = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == issue_rt)) begin
         rt_val = wb_data;
      end else begin
         rt_val = regs_q[issue_rt];
      end
   end
`else
   // Hazard view and operand read straight from the array (no forwarding)
   always_comb begin
      pend_eff = pending_q;
      if (issue_rs == R0) begin
         rs_val = {DATA_W{1'b0}};
      end else begin
         rs_val = regs_q[issue_rs];
      end
      if (issue_rt == R0) begin
         rt_val = {DATA_W{1'b0}};
      end else begin
         rt_val = regs_q[issue_rt];
      end
   end
`endif

   assign issue_ready = !rst && !pend_eff[issue_rs] && !pend_eff[issue_rt];
   assign accept      = issue_valid && issue_ready;

   // Next-state: writeback, operand capture and scoreboard update
   always_comb begin
      regs_d     = regs_q;
      pending_d  = pending_q;
      op_d_d     = op_d_q;
      op_c_d     = op_c_q;
      op_valid_d = 1'b0;
      if (wb_en && (wb_addr != R0)) begin
         regs_d[wb_addr]    = wb_data;
         pending_d[wb_addr] = 1'b0;
      end else begin
         regs_d = regs_q;
      end
      if (accept) begin
         op_d_d     = rs_val;
         op_c_d     = rt_val;
         op_valid_d = 1'b1;
         // Applied after the writeback clear so a new writer owns the register
         if (issue_we && (issue_rd != R0)) begin
            pending_d[issue_rd] = 1'b1;
         end else begin
            pending_d = pending_d;
         end
      end else begin
         op_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset that overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         pending_q  <= {NUM_REGS{1'b0}};
         op_d_q     <= {DATA_W{1'b0}};
         op_c_q     <= {DATA_W{1'b0}};
         op_valid_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         pending_q  <= pending_d;
         op_d_q     <= op_d_d;
         op_c_q     <= op_c_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign op_d     = op_d_q;
   assign op_c     = op_c_q;
   assign op_valid = op_valid_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_issue.sv
module tb_regfile_issue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       issue_valid = 1'b0;
   logic       issue_ready;
   logic [2:0] issue_rs = 3'd0;
   logic [2:0] issue_rt = 3'd0;
   logic [2:0] issue_rd = 3'd0;
   logic       issue_we = 1'b0;
   logic       wb_en = 1'b0;
   logic [2:0] wb_addr = 3'd0;
   logic [7:0] wb_data = 8'd0;
   logic [7:0] op_d;
   logic [7:0] op_c;
   logic       op_valid;
   logic [7:0] pending;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int vectors    = 0;
   int miscompares = 0;

   regfile_issue #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_we(issue_we),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .op_d(op_d), .op_c(op_c), .op_valid(op_valid), .pending(pending)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] m_r [8];
   logic [7:0] m_pend  = 8'd0;
   logic [7:0] m_d     = 8'd0;
   logic [7:0] m_c     = 8'd0;
   bit         m_valid = 1'b0;
   bit         m_last_acc = 1'b0;
   bit         started = 1'b0;

   function automatic bit m_ready();
      logic [7:0] eff;
      eff = m_pend;
      if (BYPASS && wb_en) eff[wb_addr] = 1'b0;
      return !rst && !eff[issue_rs] && !eff[issue_rt];
   endfunction

   function automatic logic [7:0] m_read(input logic [2:0] a);
      if (a == 3'd0) return 8'd0;
      if (BYPASS && wb_en && wb_addr == a) return wb_data;
      return m_r[a];
   endfunction

   always @(posedge clk) begin
      bit acc;
      started = 1'b1;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
         m_pend = 8'd0; m_d = 8'd0; m_c = 8'd0; m_valid = 1'b0;
         acc = 1'b0;
      end else begin
         acc = issue_valid && m_ready();
         if (acc) begin
            m_d = m_read(issue_rs);
            m_c = m_read(issue_rt);
         end
         m_valid = acc;
         if (wb_en && wb_addr != 3'd0) begin
            m_r[wb_addr]    = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (acc && issue_we && issue_rd != 3'd0) m_pend[issue_rd] = 1'b1;
      end
      m_last_acc = acc;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (started) begin
         vectors++;
         check("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready()});
         check("op_valid",    {31'd0, op_valid},    {31'd0, m_valid});
         check("op_d",        {24'd0, op_d},        {24'd0, m_d});
         check("op_c",        {24'd0, op_c},        {24'd0, m_c});
         check("pending",     {24'd0, pending},     {24'd0, m_pend});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input bit we);
      issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_we = we;
   endtask

   task automatic wb(input bit en, input logic [2:0] a, input logic [7:0] d);
      wb_en = en; wb_addr = a; wb_data = d;
   endtask

   initial begin
      bit hold;
      // Reset then read
      cyc();
      rst = 1'b0;
      issue(1'b1, 3'd3, 3'd5, 3'd0, 1'b0);
      cyc();
      check("lit_reset_valid", {31'd0, op_valid}, 32'd1);
      check("lit_reset_op_d", {24'd0, op_d}, 32'h00);
      check("lit_reset_pend", {24'd0, pending}, 32'h00);
      // Write / read
      issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      wb(1'b1, 3'd2, 8'h5A);
      cyc();
      wb(1'b0, 3'd0, 8'h00);
      issue(1'b1, 3'd2, 3'd0, 3'd0, 1'b0);
      cyc();
      check("lit_wr_op_d", {24'd0, op_d}, 32'h5A);
      check("lit_wr_op_c", {24'd0, op_c}, 32'h00);
      // R0 protection
      wb(1'b1, 3'd0, 8'hFF);
      issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b1);
      cyc();
      wb(1'b0, 3'd0, 8'h00);
      issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b0);
      cyc();
      check("lit_r0_op_d", {24'd0, op_d}, 32'h00);
      check("lit_r0_pend0", {31'd0, pending[0]}, 32'd0);
      // RAW stall
      issue(1'b1, 3'd0, 3'd0, 3'd4, 1'b1);
      cyc();
      check("lit_raw_pend", {24'd0, pending}, 32'h10);
      issue(1'b1, 3'd4, 3'd0, 3'd0, 1'b0);
      #1;
      check("lit_raw_ready0", {31'd0, issue_ready}, 32'd0);
      cyc();
      check("lit_raw_stall", {31'd0, op_valid}, 32'd0);
      wb(1'b1, 3'd4, 8'h33);
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      check("lit_raw_byp_ready", {31'd0, issue_ready}, 32'd1);
      cyc();
      check("lit_raw_byp_valid", {31'd0, op_valid}, 32'd1);
      check("lit_raw_byp_op_d", {24'd0, op_d}, 32'h33);
      wb(1'b0, 3'd0, 8'h00);
`else
      check("lit_raw_wb_ready", {31'd0, issue_ready}, 32'd0);
      cyc();
      check("lit_raw_wb_valid", {31'd0, op_valid}, 32'd0);
      wb(1'b0, 3'd0, 8'h00);
      #1;
      check("lit_raw_after_ready", {31'd0, issue_ready}, 32'd1);
      cyc();
      check("lit_raw_valid", {31'd0, op_valid}, 32'd1);
      check("lit_raw_op_d", {24'd0, op_d}, 32'h33);
`endif
      // Set/clear collision
      issue(1'b1, 3'd0, 3'd0, 3'd6, 1'b1);
      cyc();
      wb(1'b1, 3'd6, 8'h77);
      issue(1'b1, 3'd0, 3'd0, 3'd6, 1'b1);
      cyc();
      check("lit_collide_pend6", {31'd0, pending[6]}, 32'd1);
      issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      cyc();
      wb(1'b0, 3'd0, 8'h00);
      // Reset mid-operation
      issue(1'b1, 3'd0, 3'd0, 3'd4, 1'b1);
      cyc();
      issue(1'b1, 3'd0, 3'd0, 3'd5, 1'b1);
      cyc();
      check("lit_mid_pend", {24'd0, pending}, 32'h30);
      wb(1'b1, 3'd4, 8'h99);
      issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wb(1'b0, 3'd0, 8'h00);
      issue(1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
      check("lit_rst_pend", {24'd0, pending}, 32'h00);
      check("lit_rst_valid", {31'd0, op_valid}, 32'd0);
      issue(1'b1, 3'd4, 3'd5, 3'd0, 1'b0);
      cyc();
      check("lit_rst_r4", {24'd0, op_d}, 32'h00);

      // Randomized phase; issue_* held stable while stalled
      for (int n = 0; n < 3000; n++) begin
         hold = issue_valid && !m_last_acc;
         rst = ($urandom_range(0, 199) == 0);
         if (!hold) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rs = 3'($urandom_range(0, 7));
            issue_rt = 3'($urandom_range(0, 7));
            issue_rd = 3'($urandom_range(0, 7));
            issue_we = ($urandom_range(0, 1) == 1);
         end
         wb_en   = ($urandom_range(0, 2) == 0);
         wb_addr = 3'($urandom_range(0, 7));
         wb_data = 8'($urandom_range(0, 255));
         cyc();
      end
      rst = 1'b0;
      issue_valid = 1'b0;
      wb_en = 1'b0;
      cyc();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
